// File: rtl/alu_pkg.sv
// Shared mALU definitions: opcode encodings, arbiter FSM states, default datapath width.
// Opcodes 000..100 are logic ops (carry meaningless), 101..111 are arithmetic.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] ALU_OP_AND  = 3'b000;
    localparam logic [2:0] ALU_OP_OR   = 3'b001;
    localparam logic [2:0] ALU_OP_XOR  = 3'b010;
    localparam logic [2:0] ALU_OP_NOT  = 3'b011;
    localparam logic [2:0] ALU_OP_PASS = 3'b100;
    localparam logic [2:0] ALU_OP_ADD  = 3'b101;
    localparam logic [2:0] ALU_OP_SUB  = 3'b110;
    localparam logic [2:0] ALU_OP_INC  = 3'b111;

    localparam logic [2:0] ALU_OP_ARITH_MIN = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FLAG = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    function automatic logic alu_is_arith(input logic [2:0] op);
        return op >= ALU_OP_ARITH_MIN;
    endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Round-robin one-hot pick: first set bit of valid at or after ptr, wrapping at NREQ-1.
// Latency: combinational. Backpressure: none, pure function of valid and ptr.
// Pointer values are always kept in 0..NREQ-1 by the caller.
module alu_rr_picker #(
    parameter int NREQ = 2,
    parameter int PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [PTRW-1:0] idx,
    output logic            any_vld
);

    logic [PTRW-1:0] cand;

    always_comb begin
        idx     = '0;
        any_vld = 1'b0;
        cand    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_vld && valid[cand]) begin
                any_vld = 1'b1;
                idx     = cand;
            end
            cand = (cand == PTRW'(NREQ - 1)) ? '0 : cand + 1'b1;
        end
        grant = any_vld ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one mALU between NREQ requesters; round-robin grant, optional grant lock (ALU_ARB_LOCK_EN).
// Latency: handshake edge -> response valid 3 cycles later; one op in flight, 1 op per 4 cycles max.
// Backpressure: response held until iRspReady; no new request accepted until it is taken.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                  iClock,
    input  logic                  iResetn,
    input  logic [NREQ-1:0]       iReqValid,
    output logic [NREQ-1:0]       oReqReady,
    input  logic [3*NREQ-1:0]     iReqOpcode,
    input  logic [WIDTH*NREQ-1:0] iReqA,
    input  logic [WIDTH*NREQ-1:0] iReqB,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]       iReqLock,
`endif
    output logic [NREQ-1:0]       oRspValid,
    input  logic                  iRspReady,
    output logic [WIDTH-1:0]      oRspData,
    output logic                  oRspCarry,
    output logic                  oRspZero,
    output logic [WIDTH-1:0]      oAluA,
    output logic [WIDTH-1:0]      oAluB,
    output logic [2:0]            oAluOpcode,
    input  logic [WIDTH-1:0]      iAluAcc,
    input  logic                  iAluCarry,
    input  logic                  iAluZero
);

    localparam int PTRW = $clog2(NREQ);

    arb_state_e      state_q,    state_d;
    logic [PTRW-1:0] ptr_q,      ptr_d;
    logic [PTRW-1:0] grant_q,    grant_d;
    logic [2:0]      op_q,       op_d;
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic [2:0]      alu_op_q,   alu_op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic            rsp_zero_q,  rsp_zero_d;
    logic            lock_q,     lock_d;

    logic [NREQ-1:0] pick_vld;
    logic [NREQ-1:0] pick_grant;
    logic [PTRW-1:0] pick_idx;
    logic            pick_any;
    logic            req_hs;
    logic            req_lock;

    // A held lock narrows the candidate set to the previous owner only.
    always_comb begin
        pick_vld = iReqValid;
        req_lock = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        if (lock_q) begin
            pick_vld = iReqValid & (NREQ'(1) << grant_q);
        end
        req_lock = iReqLock[pick_idx];
`endif
    end

    alu_rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_picker (
        .valid   (pick_vld),
        .ptr     (ptr_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_vld (pick_any)
    );

    assign oReqReady = (state_q == IDLE && iResetn) ? pick_grant : '0;
    assign req_hs    = pick_any && (state_q == IDLE) && iResetn;

    assign oRspValid  = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
    assign oRspData   = rsp_data_q;
    assign oRspCarry  = rsp_carry_q;
    assign oRspZero   = rsp_zero_q;
    assign oAluA      = alu_a_q;
    assign oAluB      = alu_b_q;
    assign oAluOpcode = alu_op_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        lock_d      = lock_q;
        // Issue regs are live only during EXEC; elsewhere the ALU sees a zero logic op.
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = ALU_OP_AND;

        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    grant_d  = pick_idx;
                    op_d     = iReqOpcode[3*pick_idx +: 3];
                    alu_op_d = iReqOpcode[3*pick_idx +: 3];
                    alu_a_d  = iReqA[WIDTH*pick_idx +: WIDTH];
                    alu_b_d  = iReqB[WIDTH*pick_idx +: WIDTH];
                    lock_d   = req_lock;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = iAluAcc;
                state_d    = FLAG;
            end
            FLAG: begin
                rsp_zero_d  = iAluZero;
                rsp_carry_d = iAluCarry & alu_is_arith(op_q);
                state_d     = RESP;
            end
            RESP: begin
                if (iRspReady) begin
                    state_d = IDLE;
                    if (!lock_q) begin
                        ptr_d = (grant_q == PTRW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            op_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_OP_AND;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            op_q        <= op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            lock_q      <= lock_d;
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural mALU; lock steps need ALU_ARB_LOCK_EN.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_vld;
    logic [1:0]  req_rdy;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_lock;
    logic [1:0]  rsp_vld;
    logic        rsp_rdy;
    logic [15:0] rsp_dat;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_acc;
    logic        alu_cout;
    logic        alu_cflag = 1'b0;
    logic        alu_zflag = 1'b0;
    logic        dirty_carry = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.NREQ(2), .WIDTH(16)) dut (
        .iClock     (clk),
        .iResetn    (rst_n),
        .iReqValid  (req_vld),
        .oReqReady  (req_rdy),
        .iReqOpcode (req_op),
        .iReqA      (req_a),
        .iReqB      (req_b),
`ifdef ALU_ARB_LOCK_EN
        .iReqLock   (req_lock),
`endif
        .oRspValid  (rsp_vld),
        .iRspReady  (rsp_rdy),
        .oRspData   (rsp_dat),
        .oRspCarry  (rsp_carry),
        .oRspZero   (rsp_zero),
        .oAluA      (alu_a),
        .oAluB      (alu_b),
        .oAluOpcode (alu_op),
        .iAluAcc    (alu_acc),
        .iAluCarry  (alu_cflag),
        .iAluZero   (alu_zflag)
    );

    // mALU model: combinational accumulator, registered flags. dirty_carry lets the
    // carry flop misbehave on logic ops so the arbiter's own carry masking is visible.
    always_comb begin
        logic [16:0] s;
        s        = 17'h0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b000: alu_acc = alu_a & alu_b;
            3'b001: alu_acc = alu_a | alu_b;
            3'b010: alu_acc = alu_a ^ alu_b;
            3'b011: alu_acc = ~alu_a;
            3'b100: alu_acc = alu_b;
            3'b101: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_acc = s[15:0]; alu_cout = s[16]; end
            3'b110: begin alu_acc = alu_a - alu_b; alu_cout = (alu_a < alu_b); end
            default: begin alu_acc = alu_a + 16'h1; alu_cout = (alu_a == 16'hffff); end
        endcase
    end

    always @(posedge clk) begin
        alu_cflag <= (alu_op >= 3'b101) ? alu_cout : dirty_carry;
        alu_zflag <= (alu_acc == 16'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        if (r == 0) begin
            req_op[2:0] = op; req_a[15:0] = a; req_b[15:0] = b;
        end else begin
            req_op[5:3] = op; req_a[31:16] = a; req_b[31:16] = b;
        end
    endtask

    // Starts in IDLE with requests already driven; runs one op through to acceptance.
    task automatic op_cycle(input string tag, input logic [1:0] gnt, input logic [2:0] op,
                            input logic [15:0] dat, input logic z, input logic c);
        #1;
        chk({tag, ".ready"}, 32'(req_rdy), 32'(gnt));
        tick();
        chk({tag, ".busy_rdy"}, 32'(req_rdy), 32'h0);
        chk({tag, ".exec_op"}, 32'(alu_op), 32'(op));
        tick();
        chk({tag, ".flag_op"}, 32'(alu_op), 32'h0);
        chk({tag, ".flag_vld"}, 32'(rsp_vld), 32'h0);
        tick();
        chk({tag, ".rsp_vld"}, 32'(rsp_vld), 32'(gnt));
        chk({tag, ".data"}, 32'(rsp_dat), 32'(dat));
        chk({tag, ".zero"}, 32'(rsp_zero), 32'(z));
        chk({tag, ".carry"}, 32'(rsp_carry), 32'(c));
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk({tag, ".rsp_done"}, 32'(rsp_vld), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; req_vld = 2'b00; req_op = '0; req_a = '0; req_b = '0;
        req_lock = 2'b00; rsp_rdy = 1'b0;
        tick();
        tick();
        chk("rst.ready", 32'(req_rdy), 32'h0);
        chk("rst.rsp_vld", 32'(rsp_vld), 32'h0);
        chk("rst.data", 32'(rsp_dat), 32'h0);
        chk("rst.flags", 32'({rsp_carry, rsp_zero}), 32'h0);
        chk("rst.alu_op", 32'(alu_op), 32'h0);
        chk("rst.alu_ab", {alu_a, alu_b}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single ADD from req0; operands must reach the ALU in EXEC.
        set_req(0, 3'b101, 16'h0003, 16'h0004);
        req_vld = 2'b01;
        #1;
        chk("add.ready0", 32'(req_rdy), 32'h1);
        tick();
        req_vld = 2'b00;
        chk("add.alu_a", 32'(alu_a), 32'h3);
        chk("add.alu_b", 32'(alu_b), 32'h4);
        tick();
        chk("add.alu_a_clr", 32'(alu_a), 32'h0);
        tick();
        chk("add.rsp_vld", 32'(rsp_vld), 32'h1);
        chk("add.data", 32'(rsp_dat), 32'h7);
        chk("add.flags", 32'({rsp_carry, rsp_zero}), 32'h0);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("add.done", 32'(rsp_vld), 32'h0);

        // Pointer is 1, only req0 valid: wrap-around search; logic op carry masked.
        dirty_carry = 1'b1;
        set_req(0, 3'b000, 16'h0000, 16'h0000);
        req_vld = 2'b01;
        op_cycle("and0", 2'b01, 3'b000, 16'h0000, 1'b1, 1'b0);
        req_vld = 2'b00;
        dirty_carry = 1'b0;

        // Arithmetic carry-out with zero result from req1.
        set_req(1, 3'b101, 16'hffff, 16'h0001);
        req_vld = 2'b10;
        op_cycle("addc", 2'b10, 3'b101, 16'h0000, 1'b1, 1'b1);
        req_vld = 2'b00;

        // Both valid continuously: grants must alternate.
        set_req(0, 3'b101, 16'h0010, 16'h0020);
        set_req(1, 3'b110, 16'h0050, 16'h0010);
        req_vld = 2'b11;
        op_cycle("rr1", 2'b01, 3'b101, 16'h0030, 1'b0, 1'b0);
        op_cycle("rr2", 2'b10, 3'b110, 16'h0040, 1'b0, 1'b0);
        op_cycle("rr3", 2'b01, 3'b101, 16'h0030, 1'b0, 1'b0);
        op_cycle("rr4", 2'b10, 3'b110, 16'h0040, 1'b0, 1'b0);

        // Response held for 5 cycles with both still requesting.
        set_req(0, 3'b010, 16'h00ff, 16'h0f0f);
        #1;
        chk("bp.ready", 32'(req_rdy), 32'h1);
        tick();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp.hold_vld", 32'(rsp_vld), 32'h1);
            chk("bp.hold_data", 32'(rsp_dat), 32'h0ff0);
            chk("bp.hold_rdy", 32'(req_rdy), 32'h0);
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("bp.done", 32'(rsp_vld), 32'h0);
        chk("bp.next_gnt", 32'(req_rdy), 32'h2);
        req_vld = 2'b00;
        tick();

        // Reset asserted during FLAG: op dropped, pointer back to 0.
        set_req(1, 3'b101, 16'h0001, 16'h0001);
        req_vld = 2'b10;
        #1;
        chk("mid.ready", 32'(req_rdy), 32'h2);
        tick();
        req_vld = 2'b00;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid.rsp_vld", 32'(rsp_vld), 32'h0);
        chk("mid.data", 32'(rsp_dat), 32'h0);
        chk("mid.alu_op", 32'(alu_op), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid.no_rsp", 32'(rsp_vld), 32'h0);
        end
        req_vld = 2'b11;
        #1;
        chk("mid.rr_zero", 32'(req_rdy), 32'h1);
        req_vld = 2'b00;
        tick();

`ifdef ALU_ARB_LOCK_EN
        set_req(1, 3'b101, 16'h0005, 16'h0006);
        req_lock = 2'b10;
        req_vld  = 2'b10;
        op_cycle("lk1", 2'b10, 3'b101, 16'h000b, 1'b0, 1'b0);
        req_lock = 2'b00;
        set_req(0, 3'b100, 16'h0000, 16'h1234);
        set_req(1, 3'b110, 16'h0009, 16'h0002);
        req_vld = 2'b11;
        op_cycle("lk2", 2'b10, 3'b110, 16'h0007, 1'b0, 1'b0);
        op_cycle("lk3", 2'b01, 3'b100, 16'h1234, 1'b0, 1'b0);
        req_vld = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
